// File: rtl/bram_mport_pkg.sv
// Shared defaults and helpers for the bram_mport instruction/data memory.
package bram_mport_pkg;

  localparam int unsigned DEF_WORD_SIZE  = 16;
  localparam int unsigned DEF_INSN_W     = 20;
  localparam int unsigned DEF_IADDR_W    = 10;
  localparam int unsigned DEF_DADDR_W    = 5;
  localparam int unsigned DEF_IMEM_DEPTH = 1024;
  localparam int unsigned DEF_DMEM_DEPTH = 32;
  localparam int unsigned DEF_NUM_IPORTS = 2;

  // Bits needed to index n entries; never less than one so 1-entry cases stay legal.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_mport_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module bram_mport_rr_arbiter
  import bram_mport_pkg::*;
#(
  parameter int unsigned  N  = DEF_NUM_IPORTS,
  localparam int unsigned PW = idx_bits(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_gidx
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Scan requesters starting at the pointer; nothing is granted while in reset.
  always_comb begin
    o_gnt   = '0;
    o_gidx  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PW'((32'(r_ptr) + i) % N);
      if (!w_found && !i_rst && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gidx       = w_idx;
        w_found      = 1'b1;
      end
    end
  end

  // Pointer moves to the channel after the one just granted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= PW'((32'(o_gidx) + 1) % N);
    end
  end

endmodule

// File: rtl/bram_mport.sv
// Multi-channel instruction fetch memory plus write-first data memory for the ECC core.
module bram_mport
  import bram_mport_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter int unsigned INSN_W     = DEF_INSN_W,
  parameter int unsigned IADDR_W    = DEF_IADDR_W,
  parameter int unsigned DADDR_W    = DEF_DADDR_W,
  parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int unsigned DMEM_DEPTH = DEF_DMEM_DEPTH,
  parameter int unsigned NUM_IPORTS = DEF_NUM_IPORTS
) (
  input  logic                         idclk,
  input  logic                         rst,
  input  logic [NUM_IPORTS-1:0]        i_req,
  input  logic [NUM_IPORTS*IADDR_W-1:0] i_addr,
  output logic [NUM_IPORTS-1:0]        i_gnt,
  output logic [NUM_IPORTS-1:0]        i_valid,
  output logic [NUM_IPORTS*INSN_W-1:0] i_data,
  input  logic                         gwe,
  input  logic                         d_re,
  input  logic [DADDR_W-1:0]           d_raddr,
  output logic [WORD_SIZE-1:0]         d_dout,
  output logic                         d_dvalid,
  input  logic                         d_we,
  input  logic [DADDR_W-1:0]           d_waddr,
  input  logic [WORD_SIZE-1:0]         d_din
);

  localparam int unsigned GW  = idx_bits(NUM_IPORTS);
  localparam int unsigned IIW = idx_bits(IMEM_DEPTH);
  localparam int unsigned DIW = idx_bits(DMEM_DEPTH);

  logic [INSN_W-1:0]    r_imem [IMEM_DEPTH];
  logic [WORD_SIZE-1:0] r_dmem [DMEM_DEPTH];

  logic [NUM_IPORTS-1:0] w_gnt;
  logic [GW-1:0]         w_gidx;
  logic [IADDR_W-1:0]    w_faddr;
  logic                  w_finrange;
  logic [INSN_W-1:0]     r_fetch;
  logic [NUM_IPORTS-1:0] r_ivalid;

  logic                  w_wcommit;
  logic                  w_rinrange;
  logic [WORD_SIZE-1:0]  r_dout;
  logic                  r_dvalid;

  bram_mport_rr_arbiter #(
    .N (NUM_IPORTS)
  ) u_arb (
    .i_clk  (idclk),
    .i_rst  (rst),
    .i_req  (i_req),
    .o_gnt  (w_gnt),
    .o_gidx (w_gidx)
  );

  assign i_gnt      = w_gnt;
  assign i_valid    = r_ivalid;
  assign w_faddr    = i_addr[w_gidx*IADDR_W +: IADDR_W];
  assign w_finrange = (32'(w_faddr) < IMEM_DEPTH);

  // Single shared array read: the granted channel's word lands in r_fetch one cycle later.
  always_ff @(posedge idclk) begin
    if (rst) begin
      r_fetch  <= '0;
      r_ivalid <= '0;
    end else begin
      r_ivalid <= w_gnt;
      if (|w_gnt) begin
        r_fetch <= w_finrange ? r_imem[IIW'(w_faddr)] : '0;
      end
    end
  end

  // Per-channel hold: valid cycle shows r_fetch directly, afterwards the captured copy,
  // so a back-to-back grant to the same channel cannot disturb the word already shown.
  for (genvar k = 0; k < NUM_IPORTS; k++) begin : g_ch
    logic [INSN_W-1:0] r_hold;

    // Capture the fetched word on the channel's valid cycle.
    always_ff @(posedge idclk) begin
      if (rst) begin
        r_hold <= '0;
      end else if (r_ivalid[k]) begin
        r_hold <= r_fetch;
      end
    end

    assign i_data[k*INSN_W +: INSN_W] = r_ivalid[k] ? r_fetch : r_hold;
  end

  assign w_wcommit  = d_we && (d_re || gwe) && (32'(d_waddr) < DMEM_DEPTH);
  assign w_rinrange = (32'(d_raddr) < DMEM_DEPTH);
  assign d_dout     = r_dout;
  assign d_dvalid   = r_dvalid;

  // Data array write port; out-of-range addresses are dropped.
  always_ff @(posedge idclk) begin
    if (w_wcommit) begin
      r_dmem[DIW'(d_waddr)] <= d_din;
    end
  end

  // Registered data read with write-first bypass on an address match.
  always_ff @(posedge idclk) begin
    if (rst) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= d_re;
      if (d_re) begin
        if (!w_rinrange) begin
          r_dout <= '0;
        end else if (w_wcommit && (d_waddr == d_raddr)) begin
          r_dout <= d_din;
        end else begin
          r_dout <= r_dmem[DIW'(d_raddr)];
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_mport.sv
// Directed bench for bram_mport: a 2-channel default instance and a 4-channel wide-address instance.
module tb_bram_mport;

  logic idclk;
  logic rst;

  logic [1:0]  a_req;
  logic [19:0] a_addr;
  logic [1:0]  a_gnt, a_valid;
  logic [39:0] a_data;
  logic        a_gwe, a_dre, a_dwe, a_dvalid;
  logic [4:0]  a_raddr, a_waddr;
  logic [15:0] a_dout, a_din;

  logic [3:0]  b_req;
  logic [43:0] b_addr;
  logic [3:0]  b_gnt, b_valid;
  logic [79:0] b_data;
  logic        b_gwe, b_dre, b_dwe, b_dvalid;
  logic [5:0]  b_raddr, b_waddr;
  logic [15:0] b_dout, b_din;

  int n_tests = 0;
  int n_fail  = 0;

  bram_mport dut_a (
    .idclk(idclk), .rst(rst),
    .i_req(a_req), .i_addr(a_addr), .i_gnt(a_gnt), .i_valid(a_valid), .i_data(a_data),
    .gwe(a_gwe), .d_re(a_dre), .d_raddr(a_raddr), .d_dout(a_dout), .d_dvalid(a_dvalid),
    .d_we(a_dwe), .d_waddr(a_waddr), .d_din(a_din)
  );

  bram_mport #(
    .IADDR_W    (11),
    .DADDR_W    (6),
    .IMEM_DEPTH (1024),
    .DMEM_DEPTH (32),
    .NUM_IPORTS (4)
  ) dut_b (
    .idclk(idclk), .rst(rst),
    .i_req(b_req), .i_addr(b_addr), .i_gnt(b_gnt), .i_valid(b_valid), .i_data(b_data),
    .gwe(b_gwe), .d_re(b_dre), .d_raddr(b_raddr), .d_dout(b_dout), .d_dvalid(b_dvalid),
    .d_we(b_dwe), .d_waddr(b_waddr), .d_din(b_din)
  );

  initial idclk = 1'b0;
  always #5 idclk = ~idclk;

  task automatic tick;
    @(posedge idclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  exp2;
  logic [3:0]  seq_gnt [4];
  int          seq_ch  [4];
  logic [19:0] seq_dat [4];

  initial begin
    rst = 1'b1;
    a_req = '0; a_addr = '0; a_gwe = 0; a_dre = 0; a_dwe = 0; a_raddr = '0; a_waddr = '0; a_din = '0;
    b_req = '0; b_addr = '0; b_gwe = 0; b_dre = 0; b_dwe = 0; b_raddr = '0; b_waddr = '0; b_din = '0;

    dut_a.r_imem[5]  = 20'hABCDE;
    dut_a.r_imem[6]  = 20'h11111;
    dut_a.r_imem[9]  = 20'h22222;
    dut_b.r_imem[10] = 20'hA0001;
    dut_b.r_imem[11] = 20'hA0002;
    dut_b.r_imem[12] = 20'hA0003;

    tick; tick;

    // Reset pulsed while a fetch is in flight
    rst = 1'b0; a_req = 2'b01; a_addr[9:0] = 10'd5;
    #1; chk("rst_pre_gnt", 80'(a_gnt), 80'(2'b01));
    tick;
    chk("rst_pre_valid", 80'(a_valid), 80'(2'b01));
    chk("rst_pre_data", 80'(a_data[19:0]), 80'(20'hABCDE));
    rst = 1'b1;
    #1; chk("rst_gnt_masked", 80'(a_gnt), 80'(2'b00));
    tick;
    chk("rst_valid", 80'(a_valid), 80'(2'b00));
    chk("rst_data", 80'(a_data), 80'(40'h0));
    chk("rst_dout", 80'(a_dout), 80'(16'h0));
    chk("rst_dvalid", 80'(a_dvalid), 80'(1'b0));
    chk("rst_b_valid", 80'(b_valid), 80'(4'h0));
    chk("rst_b_dout", 80'(b_dout), 80'(16'h0));
    rst = 1'b0; a_req = 2'b00;
    tick;
    chk("rst_fetch_discard", 80'(a_valid), 80'(2'b00));

    // Single channel fetch and hold
    a_req = 2'b01; a_addr[9:0] = 10'd5;
    #1; chk("single_gnt", 80'(a_gnt), 80'(2'b01));
    tick;
    a_req = 2'b00;
    chk("single_valid", 80'(a_valid), 80'(2'b01));
    chk("single_data", 80'(a_data[19:0]), 80'(20'hABCDE));
    tick; tick; tick; tick;
    chk("single_hold_valid", 80'(a_valid), 80'(2'b00));
    chk("single_hold_data", 80'(a_data[19:0]), 80'(20'hABCDE));

    // Back-to-back grants to a lone requester
    a_req = 2'b01; a_addr[9:0] = 10'd5;
    #1; chk("b2b_gnt0", 80'(a_gnt), 80'(2'b01));
    tick;
    a_addr[9:0] = 10'd6;
    #1; chk("b2b_gnt1", 80'(a_gnt), 80'(2'b01));
    chk("b2b_data0", 80'(a_data[19:0]), 80'(20'hABCDE));
    tick;
    a_req = 2'b00;
    chk("b2b_valid1", 80'(a_valid), 80'(2'b01));
    chk("b2b_data1", 80'(a_data[19:0]), 80'(20'h11111));
    tick;
    chk("b2b_hold_valid", 80'(a_valid), 80'(2'b00));
    chk("b2b_hold_data", 80'(a_data[19:0]), 80'(20'h11111));

    // Channel 1 alone; leaves the pointer at 0
    a_req = 2'b10; a_addr[19:10] = 10'd9;
    #1; chk("ch1_gnt", 80'(a_gnt), 80'(2'b10));
    tick;
    a_req = 2'b00;
    chk("ch1_valid", 80'(a_valid), 80'(2'b10));
    chk("ch1_data", 80'(a_data[39:20]), 80'(20'h22222));

    // Contention: grants alternate starting with channel 0
    a_req = 2'b11; a_addr = {10'd9, 10'd5};
    for (int c = 0; c < 100; c++) begin
      exp2 = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1; chk("rr_gnt", 80'(a_gnt), 80'(exp2));
      tick;
      chk("rr_valid", 80'(a_valid), 80'(exp2));
      if (exp2[0]) chk("rr_data0", 80'(a_data[19:0]), 80'(20'hABCDE));
      else         chk("rr_data1", 80'(a_data[39:20]), 80'(20'h22222));
    end
    a_req = 2'b00;
    tick;

    // Write-first on same address
    a_dwe = 1; a_gwe = 1; a_dre = 1; a_waddr = 5'd7; a_raddr = 5'd7; a_din = 16'h1234;
    tick;
    chk("wf_dout", 80'(a_dout), 80'(16'h1234));
    chk("wf_dvalid", 80'(a_dvalid), 80'(1'b1));
    a_dwe = 0; a_gwe = 0; a_dre = 0;
    tick;
    chk("rd_idle_dvalid", 80'(a_dvalid), 80'(1'b0));
    chk("rd_idle_hold", 80'(a_dout), 80'(16'h1234));

    // Write gated off when neither d_re nor gwe
    a_dwe = 1; a_gwe = 0; a_dre = 0; a_waddr = 5'd7; a_din = 16'h5555;
    tick;
    a_dwe = 0; a_dre = 1; a_raddr = 5'd7;
    tick;
    chk("gate_nowrite", 80'(a_dout), 80'(16'h1234));
    a_dwe = 1; a_gwe = 1; a_dre = 0; a_waddr = 5'd3; a_din = 16'h3333;
    tick;
    a_dwe = 0; a_gwe = 0; a_dre = 1; a_raddr = 5'd3;
    tick;
    chk("gate_gwe_write", 80'(a_dout), 80'(16'h3333));
    a_dwe = 1; a_gwe = 0; a_dre = 1; a_waddr = 5'd4; a_raddr = 5'd4; a_din = 16'h4444;
    tick;
    chk("gate_dre_write", 80'(a_dout), 80'(16'h4444));
    a_dwe = 0; a_dre = 0;
    tick;
    chk("gate_hold", 80'(a_dout), 80'(16'h4444));

    // Out-of-range data addresses on the 6-bit instance
    b_dwe = 1; b_gwe = 1; b_waddr = 6'd8; b_din = 16'h0808;
    tick;
    b_waddr = 6'd40; b_din = 16'hBEEF;
    tick;
    b_dwe = 0; b_gwe = 0; b_dre = 1; b_raddr = 6'd8;
    tick;
    chk("oor_wr_drop", 80'(b_dout), 80'(16'h0808));
    b_raddr = 6'd40;
    tick;
    chk("oor_rd_zero", 80'(b_dout), 80'(16'h0));
    chk("oor_rd_dvalid", 80'(b_dvalid), 80'(1'b1));
    b_dre = 0;

    // Four channels: move pointer to 3, then all request
    b_req = 4'b0100; b_addr[22 +: 11] = 11'd12;
    #1; chk("n4_pre_gnt", 80'(b_gnt), 80'(4'b0100));
    tick;
    b_req = 4'b0000;
    chk("n4_pre_valid", 80'(b_valid), 80'(4'b0100));
    chk("n4_pre_data", 80'(b_data[40 +: 20]), 80'(20'hA0003));
    b_addr = {11'd1500, 11'd12, 11'd11, 11'd10};
    b_req = 4'b1111;
    seq_gnt = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    seq_ch  = '{3, 0, 1, 2};
    seq_dat = '{20'h0, 20'hA0001, 20'hA0002, 20'hA0003};
    for (int j = 0; j < 4; j++) begin
      #1; chk("n4_gnt", 80'(b_gnt), 80'(seq_gnt[j]));
      tick;
      chk("n4_valid", 80'(b_valid), 80'(seq_gnt[j]));
      chk("n4_data", 80'(b_data[seq_ch[j]*20 +: 20]), 80'(seq_dat[j]));
    end
    b_req = 4'b0000;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
